fence_exec: RTL and testbench

- Execute-stage responder for decoded RV32I fence instructions; it carries out what the fence decoder classifies.
- Accepts one fence request per handshake and orders memory by draining the store buffer.
- For fence.i it also invalidates the I-cache and flushes and redirects the front end.
- Reports completion or illegal kind back to the pipeline control.

---
 rtl/fence_exec_if.sv | 40 ++++
 rtl/fence_exec.sv | 158 +++++++++++++++
 tb/tb_fence_exec.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/fence_exec_if.sv
// Fence request handshake bundle between issue and the fence execute unit,
// plus the shared fence-kind encoding.
package fence_exec_pkg;
    typedef enum logic [1:0] {
        fk_fence   = 2'd0,
        fk_fence_i = 2'd1,
        fk_invalid = 2'd2
    } fence_kind_t;
endpackage

interface fence_exec_if
    import fence_exec_pkg::*;
#(
    parameter int unsigned XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    fence_kind_t     kind;
    logic [3:0]      pred;
    logic [3:0]      succ;
    logic [XLEN-1:0] pc;

    modport master (
        output req_valid,
        output kind,
        output pred,
        output succ,
        output pc,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  kind,
        input  pred,
        input  succ,
        input  pc,
        output req_ready
    );
endinterface

// File: rtl/fence_exec.sv
// Execute-stage fence responder: drains the store buffer, and for fence.i also
// invalidates the I-cache and redirects fetch. Optional watchdog: FENCE_EXEC_TIMEOUT_EN.
module fence_exec
    import fence_exec_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic            clk,
    input  logic            rst,
    fence_exec_if.slave     req,
    input  logic            sb_empty,
    output logic            sb_drain,
    output logic            ic_inv_req,
    input  logic            ic_inv_ack,
    output logic            flush,
    output logic [XLEN-1:0] redirect_pc,
    output logic            done,
    output logic            illegal,
    output logic            busy,
    output logic            timeout_err
);

    typedef enum logic [2:0] {
        StIdle,
        StDrain,
        StInval,
        StRedirect,
        StRetire,
        StErr,
        StTout
    } state_e;

    state_e          state_q, state_d;
    fence_kind_t     kind_q, kind_d;
    logic [3:0]      pred_q, pred_d;
    logic [3:0]      succ_q, succ_d;
    logic [XLEN-1:0] pc_q, pc_d;

    logic accept;
    logic timeout_hit;
    logic unused_latched;

    assign accept = req.req_valid && (state_q == StIdle);

    // pred is only consulted at accept; the latched copies are kept for visibility.
    assign unused_latched = ^{pred_q, succ_q};

`ifdef FENCE_EXEC_TIMEOUT_EN
    localparam int unsigned    CntW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Counts cycles already spent in the current wait state; restarts on any entry.
    always_comb begin
        cnt_d = '0;
        if ((state_q == StDrain || state_q == StInval) && state_d == state_q) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_hit = (cnt_q == CntLast);
`else
    localparam int unsigned unused_timeout = TIMEOUT_CYCLES;

    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            kind_q  <= fk_fence;
            pred_q  <= '0;
            succ_q  <= '0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            pred_q  <= pred_d;
            succ_q  <= succ_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        kind_d = kind_q;
        pred_d = pred_q;
        succ_d = succ_q;
        pc_d   = pc_q;
        if (accept) begin
            kind_d = req.kind;
            pred_d = req.pred;
            succ_d = req.succ;
            pc_d   = req.pc;
        end
    end

    // Completion is tested before the watchdog so it wins in the limit cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    unique case (req.kind)
                        fk_fence:   state_d = (req.pred[2] || req.pred[0]) ? StDrain : StRetire;
                        fk_fence_i: state_d = StDrain;
                        default:    state_d = StErr;
                    endcase
                end
            end
            StDrain: begin
                if (sb_empty) begin
                    state_d = (kind_q == fk_fence_i) ? StInval : StRetire;
                end else if (timeout_hit) begin
                    state_d = StTout;
                end
            end
            StInval: begin
                if (ic_inv_ack) begin
                    state_d = StRedirect;
                end else if (timeout_hit) begin
                    state_d = StTout;
                end
            end
            StRedirect: state_d = StRetire;
            StRetire:   state_d = StIdle;
            StErr:      state_d = StIdle;
            StTout:     state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        req.req_ready = (state_q == StIdle);
        busy          = (state_q != StIdle);
        sb_drain      = (state_q == StDrain);
        ic_inv_req    = (state_q == StInval);
        flush         = (state_q == StRedirect);
        done          = (state_q == StRetire);
        illegal       = (state_q == StErr);
        redirect_pc   = flush ? (pc_q + XLEN'(4)) : '0;
`ifdef FENCE_EXEC_TIMEOUT_EN
        timeout_err   = (state_q == StTout);
`else
        timeout_err   = 1'b0;
`endif
    end

endmodule

// File: tb/tb_fence_exec.sv
// Directed self-checking bench for fence_exec; timeout scenarios run only when
// FENCE_EXEC_TIMEOUT_EN is defined.
module tb_fence_exec;
    import fence_exec_pkg::*;

    localparam int unsigned XLEN = 32;

    logic            clk;
    logic            rst;
    logic            sb_empty;
    logic            sb_drain;
    logic            ic_inv_req;
    logic            ic_inv_ack;
    logic            flush;
    logic [XLEN-1:0] redirect_pc;
    logic            done;
    logic            illegal;
    logic            busy;
    logic            timeout_err;

    int n_vec;
    int n_err;

    fence_exec_if #(.XLEN(XLEN)) bus ();

    fence_exec #(
        .XLEN           (XLEN),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (bus),
        .sb_empty    (sb_empty),
        .sb_drain    (sb_drain),
        .ic_inv_req  (ic_inv_req),
        .ic_inv_ack  (ic_inv_ack),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .done        (done),
        .illegal     (illegal),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for one edge; returns just after the accept edge (cycle T+1).
    task automatic issue(input fence_kind_t k, input logic [3:0] p, input logic [31:0] a);
        bus.req_valid = 1'b1;
        bus.kind      = k;
        bus.pred      = p;
        bus.succ      = 4'b1111;
        bus.pc        = a;
        check("ready_at_issue", 32'(bus.req_ready), 32'd1);
        tick();
        bus.req_valid = 1'b0;
    endtask

    initial begin
        n_vec         = 0;
        n_err         = 0;
        rst           = 1'b1;
        sb_empty      = 1'b0;
        ic_inv_ack    = 1'b0;
        bus.req_valid = 1'b0;
        bus.kind      = fk_fence;
        bus.pred      = '0;
        bus.succ      = '0;
        bus.pc        = '0;
        tick();
        tick();

        // Reset state
        check("rst_ready", 32'(bus.req_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_drain", 32'(sb_drain), 32'd0);
        check("rst_inv", 32'(ic_inv_req), 32'd0);
        check("rst_flush", 32'(flush), 32'd0);
        check("rst_rpc", redirect_pc, 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_tout", 32'(timeout_err), 32'd0);
        rst = 1'b0;
        tick();

        // fence with no store ordering: done at T+1, no drain, no flush
        issue(fk_fence, 4'b0010, 32'h0000_0100);
        check("f0_done", 32'(done), 32'd1);
        check("f0_drain", 32'(sb_drain), 32'd0);
        check("f0_flush", 32'(flush), 32'd0);
        check("f0_ready", 32'(bus.req_ready), 32'd0);
        tick();
        check("f0_done_end", 32'(done), 32'd0);
        check("f0_idle", 32'(bus.req_ready), 32'd1);

        // fence with drain, store buffer busy for 5 cycles
        sb_empty = 1'b0;
        issue(fk_fence, 4'b0011, 32'h0000_0200);
        for (int i = 0; i < 6; i++) begin
            check("f1_drain", 32'(sb_drain), 32'd1);
            check("f1_ready", 32'(bus.req_ready), 32'd0);
            check("f1_done", 32'(done), 32'd0);
            check("f1_tout", 32'(timeout_err), 32'd0);
            if (i == 5) sb_empty = 1'b1;
            tick();
        end
        check("f1_done_pulse", 32'(done), 32'd1);
        check("f1_drain_off", 32'(sb_drain), 32'd0);
        check("f1_flush", 32'(flush), 32'd0);
        tick();
        check("f1_idle", 32'(bus.req_ready), 32'd1);

        // fence with drain and empty store buffer: done at T+2
        issue(fk_fence, 4'b0001, 32'h0000_0300);
        check("f2_drain_min", 32'(sb_drain), 32'd1);
        tick();
        check("f2_done", 32'(done), 32'd1);
        tick();

        // fence.i, ack three cycles after the invalidate request rises
        issue(fk_fence_i, 4'b0000, 32'h0000_2000);
        check("fi0_drain", 32'(sb_drain), 32'd1);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("fi0_inv", 32'(ic_inv_req), 32'd1);
            check("fi0_noflush", 32'(flush), 32'd0);
            tick();
        end
        check("fi0_inv_hold", 32'(ic_inv_req), 32'd1);
        ic_inv_ack = 1'b1;
        tick();
        ic_inv_ack = 1'b0;
        check("fi0_inv_drop", 32'(ic_inv_req), 32'd0);
        check("fi0_flush", 32'(flush), 32'd1);
        check("fi0_rpc", redirect_pc, 32'h0000_2004);
        check("fi0_nodone", 32'(done), 32'd0);
        tick();
        check("fi0_done", 32'(done), 32'd1);
        check("fi0_flush_off", 32'(flush), 32'd0);
        tick();
        check("fi0_idle", 32'(bus.req_ready), 32'd1);

        // fence.i at the top of the address space, ack in first INVAL cycle
        issue(fk_fence_i, 4'b0000, 32'hFFFF_FFFC);
        tick();
        check("fi1_inv", 32'(ic_inv_req), 32'd1);
        ic_inv_ack = 1'b1;
        tick();
        ic_inv_ack = 1'b0;
        check("fi1_flush", 32'(flush), 32'd1);
        check("fi1_rpc_wrap", redirect_pc, 32'h0000_0000);
        tick();
        check("fi1_done", 32'(done), 32'd1);
        tick();

        // Illegal kind
        issue(fk_invalid, 4'b0011, 32'h0000_0400);
        check("ill_pulse", 32'(illegal), 32'd1);
        check("ill_nodone", 32'(done), 32'd0);
        check("ill_nodrain", 32'(sb_drain), 32'd0);
        tick();
        check("ill_end", 32'(illegal), 32'd0);
        check("ill_ready", 32'(bus.req_ready), 32'd1);

        // Reset asserted mid-INVAL, then a stale ack
        issue(fk_fence_i, 4'b0000, 32'h0000_3000);
        tick();
        check("rinv_inv", 32'(ic_inv_req), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rinv_inv_drop", 32'(ic_inv_req), 32'd0);
        check("rinv_ready", 32'(bus.req_ready), 32'd1);
        tick();
        rst = 1'b0;
        tick();
        ic_inv_ack = 1'b1;
        tick();
        ic_inv_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rinv_flush", 32'(flush), 32'd0);
            check("rinv_done", 32'(done), 32'd0);
            check("rinv_busy", 32'(busy), 32'd0);
            tick();
        end

`ifdef FENCE_EXEC_TIMEOUT_EN
        // Store buffer never empties: watchdog fires after 8 DRAIN cycles
        sb_empty = 1'b0;
        issue(fk_fence, 4'b0001, 32'h0000_0500);
        for (int i = 0; i < 8; i++) begin
            check("to_drain", 32'(sb_drain), 32'd1);
            check("to_early", 32'(timeout_err), 32'd0);
            tick();
        end
        check("to_pulse", 32'(timeout_err), 32'd1);
        check("to_nodone", 32'(done), 32'd0);
        check("to_drain_off", 32'(sb_drain), 32'd0);
        tick();
        check("to_end", 32'(timeout_err), 32'd0);
        check("to_idle", 32'(bus.req_ready), 32'd1);

        // Completion in the limit cycle beats the watchdog
        issue(fk_fence, 4'b0001, 32'h0000_0600);
        for (int i = 0; i < 8; i++) begin
            check("tw_drain", 32'(sb_drain), 32'd1);
            if (i == 7) sb_empty = 1'b1;
            tick();
        end
        check("tw_done", 32'(done), 32'd1);
        check("tw_notout", 32'(timeout_err), 32'd0);
        tick();
        sb_empty = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
